display_timing_cfg: RTL

Runtime-reconfigurable VGA/DVI timing generator, the parametrised successor of the fixed 640x480 timing block. It sits at the head of the display pipeline in the `clk_pixel` domain and drives sync, data-enable, frame/line markers and signed screen coordinates to the framebuffer reader and the video output stage. Timing is loaded through a valid/ready config port and applied only at a frame boundary, so a mode switch never produces a torn frame.

---
 rtl/display_timing_cfg.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/display_timing_cfg.sv
// display_timing_cfg
// Runtime-reconfigurable VGA/DVI timing generator for the pixel-clock domain.
// Two timing sets are kept: the active set drives the counters, the pending
// set holds an accepted config until the last pixel of the current frame so
// that a mode change never tears a frame. All video outputs are registered
// once from the counter state, so they stay mutually aligned.
module display_timing_cfg #(
    parameter int COORDINATE_WIDTH  = 16,
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int DEF_H_RES         = 640,
    parameter int DEF_H_FP          = 16,
    parameter int DEF_H_SYNC        = 96,
    parameter int DEF_H_BP          = 48,
    parameter int DEF_V_RES         = 480,
    parameter int DEF_V_FP          = 10,
    parameter int DEF_V_SYNC        = 2,
    parameter int DEF_V_BP          = 33,
    parameter int DEF_H_POL         = 0,
    parameter int DEF_V_POL         = 0
) (
    input  logic                                clk_pixel,
    input  logic                                rst_pixel_n,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_h_res,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_h_fp,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_h_sync,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_h_bp,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_v_res,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_v_fp,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_v_sync,
    input  logic [COORDINATE_WIDTH-2:0]         cfg_v_bp,
    input  logic                                cfg_h_pol,
    input  logic                                cfg_v_pol,
    output logic                                cfg_err,
    output logic                                hsync,
    output logic                                vsync,
    output logic                                de,
    output logic                                frame,
    output logic                                line,
    output logic signed [COORDINATE_WIDTH-1:0]  sx,
    output logic signed [COORDINATE_WIDTH-1:0]  sy,
    output logic [FRAME_COUNT_WIDTH-1:0]        frame_count
);

    localparam int FW = COORDINATE_WIDTH - 1;
    localparam int XW = COORDINATE_WIDTH + 1;

    typedef struct packed {
        logic [FW-1:0] hRes;
        logic [FW-1:0] hFp;
        logic [FW-1:0] hSync;
        logic [FW-1:0] hBp;
        logic [FW-1:0] vRes;
        logic [FW-1:0] vFp;
        logic [FW-1:0] vSync;
        logic [FW-1:0] vBp;
        logic          hPol;
        logic          vPol;
    } timing_t;

    // Zero-extend a config field into the signed working width.
    function automatic logic signed [XW-1:0] ext(input logic [FW-1:0] v);
        return $signed({2'b00, v});
    endfunction

    // First (most negative) coordinate of an axis: -(porch + sync + porch).
    function automatic logic signed [XW-1:0] axisStart(input logic [FW-1:0] fp,
                                                       input logic [FW-1:0] sync,
                                                       input logic [FW-1:0] bp);
        return -(ext(fp) + ext(sync) + ext(bp));
    endfunction

    localparam timing_t DEF_TIMING = {FW'(DEF_H_RES), FW'(DEF_H_FP), FW'(DEF_H_SYNC),
                                      FW'(DEF_H_BP), FW'(DEF_V_RES), FW'(DEF_V_FP),
                                      FW'(DEF_V_SYNC), FW'(DEF_V_BP),
                                      1'(DEF_H_POL), 1'(DEF_V_POL)};
    localparam logic signed [XW-1:0] DEF_HSTART =
        axisStart(DEF_TIMING.hFp, DEF_TIMING.hSync, DEF_TIMING.hBp);
    localparam logic signed [XW-1:0] DEF_VSTART =
        axisStart(DEF_TIMING.vFp, DEF_TIMING.vSync, DEF_TIMING.vBp);
    localparam logic signed [XW-1:0] ONE = 1;

    timing_t                r_act;
    timing_t                r_pendSet;
    logic                   r_pend;
    logic signed [XW-1:0]   r_x;
    logic signed [XW-1:0]   r_y;

    timing_t                w_cfgIn;
    logic                   w_cfgOk;
    logic                   w_accept;
    logic                   w_xLast;
    logic                   w_yLast;
    logic                   w_frameEnd;
    logic                   w_inHSync;
    logic                   w_inVSync;
    logic signed [XW-1:0]   w_hStart;
    logic signed [XW-1:0]   w_vStart;
    logic signed [XW-1:0]   w_pHStart;
    logic signed [XW-1:0]   w_pVStart;
    logic signed [XW-1:0]   w_hSyncBeg;
    logic signed [XW-1:0]   w_vSyncBeg;

    assign w_cfgIn = {cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                      cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp,
                      cfg_h_pol, cfg_v_pol};

    // A config with zero resolution or zero sync width cannot form a frame.
    assign w_cfgOk   = (cfg_h_res != '0) && (cfg_h_sync != '0) &&
                       (cfg_v_res != '0) && (cfg_v_sync != '0);
    assign cfg_ready = !r_pend;
    assign w_accept  = cfg_valid && cfg_ready;

    assign w_hStart   = axisStart(r_act.hFp, r_act.hSync, r_act.hBp);
    assign w_vStart   = axisStart(r_act.vFp, r_act.vSync, r_act.vBp);
    assign w_pHStart  = axisStart(r_pendSet.hFp, r_pendSet.hSync, r_pendSet.hBp);
    assign w_pVStart  = axisStart(r_pendSet.vFp, r_pendSet.vSync, r_pendSet.vBp);
    assign w_hSyncBeg = w_hStart + ext(r_act.hFp);
    assign w_vSyncBeg = w_vStart + ext(r_act.vFp);
    assign w_inHSync  = (r_x >= w_hSyncBeg) && (r_x <= w_hSyncBeg + ext(r_act.hSync) - ONE);
    assign w_inVSync  = (r_y >= w_vSyncBeg) && (r_y <= w_vSyncBeg + ext(r_act.vSync) - ONE);
    assign w_xLast    = (r_x == ext(r_act.hRes) - ONE);
    assign w_yLast    = (r_y == ext(r_act.vRes) - ONE);
    assign w_frameEnd = w_xLast && w_yLast;

    // Pixel counters, config capture and frame-boundary swap of the timing sets.
    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            r_act     <= DEF_TIMING;
            r_pendSet <= DEF_TIMING;
            r_pend    <= 1'b0;
            r_x       <= DEF_HSTART;
            r_y       <= DEF_VSTART;
        end else begin
            if (w_xLast) begin
                if (w_yLast) begin
                    if (r_pend) begin
                        r_act  <= r_pendSet;
                        r_x    <= w_pHStart;
                        r_y    <= w_pVStart;
                        r_pend <= 1'b0;
                    end else begin
                        r_x <= w_hStart;
                        r_y <= w_vStart;
                    end
                end else begin
                    r_x <= w_hStart;
                    r_y <= r_y + ONE;
                end
            end else begin
                r_x <= r_x + ONE;
            end
            if (w_accept && w_cfgOk) begin
                r_pendSet <= w_cfgIn;
                r_pend    <= 1'b1;
            end
        end
    end

    // Output stage: one register delay from the counters for every output.
    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            sx          <= DEF_HSTART[COORDINATE_WIDTH-1:0];
            sy          <= DEF_VSTART[COORDINATE_WIDTH-1:0];
            hsync       <= ~DEF_TIMING.hPol;
            vsync       <= ~DEF_TIMING.vPol;
            de          <= 1'b0;
            frame       <= 1'b0;
            line        <= 1'b0;
            cfg_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            sx      <= r_x[COORDINATE_WIDTH-1:0];
            sy      <= r_y[COORDINATE_WIDTH-1:0];
            hsync   <= w_inHSync ? r_act.hPol : ~r_act.hPol;
            vsync   <= w_inVSync ? r_act.vPol : ~r_act.vPol;
            de      <= !r_x[XW-1] && !r_y[XW-1];
            frame   <= (r_x == w_hStart) && (r_y == w_vStart);
            line    <= (r_x == w_hStart);
            cfg_err <= w_accept && !w_cfgOk;
            if (w_frameEnd) begin
                frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
            end
        end
    end

endmodule
